// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton run controller.
package ca_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CAPTURE, S_DRAIN} cap_state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/ca_run_capture_if.sv
// Byte-stream handshake carrying captured rows out of the run controller.
interface ca_run_capture_if;
    import ca_pkg::*;

    logic [BYTE_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/ca_row_buffer.sv
// DEPTH x WIDTH row store: one write port, registered read port.
module ca_row_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Write-through so a single-row run can read the row in the same edge it lands.
    always_comb begin
        rdata_d = mem[raddr];
        if (we && (waddr == raddr)) begin
            rdata_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ca_run_capture.sv
// Run controller: seeds the CA array, captures n generations, then drains
// them as an LSB-first byte stream with valid/ready flow control.
module ca_run_capture
    import ca_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           seed,
    input  logic [$clog2(DEPTH+1)-1:0] num_rows,
    output logic [WIDTH-1:0]           ca_state,
    output logic                       ca_set_state,
    input  logic [WIDTH-1:0]           ca_row,
    ca_run_capture_if.master           m_if,
    output logic                       busy,
    output logic                       done
);

    localparam int NR_W = $clog2(DEPTH+1);
    localparam int RA_W = $clog2(DEPTH);
    localparam int BPR  = WIDTH / BYTE_W;
    localparam int BI_W = (BPR > 1) ? $clog2(BPR) : 1;

    if ((WIDTH % BYTE_W) != 0) begin : g_width_chk
        $error("ca_run_capture: WIDTH must be a multiple of 8");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("ca_run_capture: DEPTH must be a power of 2 and >= 2");
    end

    cap_state_t       state_d, state_q;
    logic [WIDTH-1:0] seed_d, seed_q;
    logic [NR_W-1:0]  n_d, n_q;
    logic [RA_W-1:0]  row_d, row_q;
    logic [BI_W-1:0]  byte_d, byte_q;
    logic             m_valid_d, m_valid_q;
    logic             done_d, done_q;

    logic             buf_we;
    logic [RA_W-1:0]  buf_raddr;
    logic [WIDTH-1:0] buf_rdata;
    logic [RA_W-1:0]  last_row;
    logic             row_last;
    logic             byte_last;
    logic             hs;
    logic [BYTE_W-1:0] byte_sel;

    assign last_row  = RA_W'(n_q - 1'b1);
    assign row_last  = (row_q == last_row);
    assign byte_last = (byte_q == BI_W'(BPR - 1));
    assign hs        = m_valid_q && m_if.m_ready;

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        n_d       = n_q;
        row_d     = row_q;
        byte_d    = byte_q;
        m_valid_d = m_valid_q;
        done_d    = 1'b0;
        buf_we    = 1'b0;
        buf_raddr = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    seed_d = seed;
                    n_d    = (num_rows > NR_W'(DEPTH)) ? NR_W'(DEPTH) : num_rows;
                    if (n_d == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_CAPTURE;
                row_d   = '0;
            end
            S_CAPTURE: begin
                // Read address sits at row 0 so the first byte is ready on DRAIN entry.
                buf_we = 1'b1;
                if (row_last) begin
                    state_d   = S_DRAIN;
                    row_d     = '0;
                    byte_d    = '0;
                    m_valid_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            S_DRAIN: begin
                buf_raddr = row_q;
                if (hs) begin
                    if (byte_last) begin
                        byte_d = '0;
                        if (row_last) begin
                            state_d   = S_IDLE;
                            m_valid_d = 1'b0;
                            done_d    = 1'b1;
                            row_d     = '0;
                        end else begin
                            row_d     = row_q + 1'b1;
                            buf_raddr = row_q + 1'b1;
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            seed_q    <= '0;
            n_q       <= '0;
            row_q     <= '0;
            byte_q    <= '0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            n_q       <= n_d;
            row_q     <= row_d;
            byte_q    <= byte_d;
            m_valid_q <= m_valid_d;
            done_q    <= done_d;
        end
    end

    ca_row_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (row_q),
        .wdata (ca_row),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    always_comb begin
        byte_sel = buf_rdata[BYTE_W-1:0];
        for (int i = 0; i < BPR; i++) begin
            if (byte_q == BI_W'(i)) begin
                byte_sel = buf_rdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Stream outputs are gated so reset forces them to zero regardless of buffer contents.
    assign m_if.m_data  = m_valid_q ? byte_sel : '0;
    assign m_if.m_valid = m_valid_q;
    assign m_if.m_last  = m_valid_q && row_last && byte_last;

    assign ca_state     = seed_q;
    assign ca_set_state = (state_q == S_LOAD);
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;

endmodule
